// File: rtl/serial_addsub_alu.sv
// serial_addsub_alu: digit-serial add / subtract / set-less-than unit.
//   Processes DIGIT bits per cycle through a ripple chain of full-adder cells
//   with a registered carry between digits. WIDTH/DIGIT run cycles per op.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start, funct      request + op code (ADD 100000, SUB 100010, SLT 101010)
//   a, b              two's complement operands
//   busy, done        busy in RUN; done pulses one cycle when results valid
//   result            result, held until next completion
//   carry, overflow   final carry-out, signed overflow (ADD/SUB only)
//   zero, illegal     result==0, funct was not recognised at acceptance

module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module serial_addsub_alu #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             illegal
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_SLT = 6'b101010;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state;
  logic [WIDTH-1:0]  opa, opb;   // shift right one digit per RUN cycle
  logic [WIDTH-1:0]  acc;        // partial sum, digits enter at the MSB end
  logic              is_slt;
  logic              cy;
  logic [CW-1:0]     cnt;

  logic [DIGIT:0]    c;
  logic [DIGIT-1:0]  s;
  logic [WIDTH-1:0]  acc_nxt, fin_res;
  logic              ovf_i, slt_bit, legal, is_sub, last;

  assign c[0] = cy;

  fa_cell u_fa [DIGIT-1:0] (
    .a  (opa[DIGIT-1:0]),
    .b  (opb[DIGIT-1:0]),
    .ci (c[DIGIT-1:0]),
    .s  (s),
    .co (c[DIGIT:1])
  );

  // After N shifts the LSB digit has travelled down to bit 0.
  assign acc_nxt = (acc >> DIGIT) | (WIDTH'(s) << (WIDTH - DIGIT));
  // Only meaningful on the last digit: carry into MSB vs carry out of MSB.
  assign ovf_i   = c[DIGIT] ^ c[DIGIT-1];
  // Sign of a-b corrected for overflow gives the true signed less-than.
  assign slt_bit = s[DIGIT-1] ^ ovf_i;
  assign fin_res = is_slt ? {{(WIDTH-1){1'b0}}, slt_bit} : acc_nxt;
  assign legal   = (funct == F_ADD) || (funct == F_SUB) || (funct == F_SLT);
  assign is_sub  = (funct == F_SUB) || (funct == F_SLT);
  assign last    = (cnt == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      opa      <= '0;
      opb      <= '0;
      acc      <= '0;
      is_slt   <= 1'b0;
      cy       <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
          if (start) begin
            if (legal) begin
              opa     <= a;
              opb     <= is_sub ? ~b : b;
              is_slt  <= (funct == F_SLT);
              cy      <= is_sub;
              cnt     <= '0;
              acc     <= '0;
              illegal <= 1'b0;
              busy    <= 1'b1;
              state   <= S_RUN;
            end else begin
              result   <= '0;
              carry    <= 1'b0;
              overflow <= 1'b0;
              zero     <= 1'b1;
              illegal  <= 1'b1;
              done     <= 1'b1;
              state    <= S_DONE;
            end
          end
        end
        S_RUN: begin
          opa <= opa >> DIGIT;
          opb <= opb >> DIGIT;
          acc <= acc_nxt;
          cy  <= c[DIGIT];
          cnt <= cnt + 1'b1;
          if (last) begin
            result   <= fin_res;
            carry    <= c[DIGIT];
            overflow <= is_slt ? 1'b0 : ovf_i;
            zero     <= (fin_res == '0);
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_addsub_alu.sv
module tb_serial_addsub_alu;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_SLT = 6'b101010;

  typedef struct packed {
    logic [31:0] r;
    logic        c, v, z, il;
    logic [31:0] acc;
  } exp_t;

  logic        clk = 0, rst_n = 0, start = 0, start1 = 0, start32 = 0;
  logic [5:0]  funct = '0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, carry, overflow, zero, illegal;
  logic [31:0] result;
  logic        busy1, done1, carry1, ovf1, zero1, ill1;
  logic [31:0] result1;
  logic        busy32, done32, carry32, ovf32, zero32, ill32;
  logic [31:0] result32;

  logic [31:0] cyc = 0;
  int          n_chk = 0, n_pass = 0;
  exp_t        q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_addsub_alu #(.WIDTH(32), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct(funct), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .carry(carry),
    .overflow(overflow), .zero(zero), .illegal(illegal));

  serial_addsub_alu #(.WIDTH(32), .DIGIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .funct(funct), .a(a), .b(b),
    .busy(busy1), .done(done1), .result(result1), .carry(carry1),
    .overflow(ovf1), .zero(zero1), .illegal(ill1));

  serial_addsub_alu #(.WIDTH(32), .DIGIT(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .funct(funct), .a(a), .b(b),
    .busy(busy32), .done(done32), .result(result32), .carry(carry32),
    .overflow(ovf32), .zero(zero32), .illegal(ill32));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    logic [32:0] t;
    e = '0;
    case (f)
      F_ADD: begin
        t = {1'b0, x} + {1'b0, y};
        e.r = t[31:0]; e.c = t[32];
        e.v = (x[31] == y[31]) && (t[31] != x[31]);
      end
      F_SUB: begin
        t = {1'b0, x} + {1'b0, ~y} + 33'd1;
        e.r = t[31:0]; e.c = t[32];
        e.v = (x[31] != y[31]) && (t[31] != x[31]);
      end
      F_SLT: begin
        t = {1'b0, x} + {1'b0, ~y} + 33'd1;
        e.c = t[32];
        e.r = {31'b0, ($signed(x) < $signed(y))};
      end
      default: e.il = 1'b1;
    endcase
    e.z = (e.r == 32'd0);
    return e;
  endfunction

  // Scoreboard: every done pulse of the main unit retires the oldest accept.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (q.size() == 0) chk("spurious_done", 1, 0);
      else begin
        e = q.pop_front();
        chk("result", result, e.r);
        chk("flags", {carry, overflow, zero, illegal}, {e.c, e.v, e.z, e.il});
        chk("latency", cyc - e.acc, e.il ? 0 : 8);
      end
    end
  end

  task automatic issue(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    int t = 0;
    while (busy && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) chk("issue_timeout", 1, 0);
    funct = f; a = x; b = y; start = 1;
    e = model(f, x, y);
    e.acc = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    start = 0;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 300) begin @(negedge clk); t++; end
    if (t >= 300) chk("drain_timeout", 1, 0);
  endtask

  task automatic alt(input int w);
    int n = 0;
    funct = F_ADD; a = 32'd5; b = 32'd3;
    if (w == 1) start1 = 1; else start32 = 1;
    @(negedge clk);
    start1 = 0; start32 = 0;
    while (!(w == 1 ? done1 : done32) && n < 100) begin @(negedge clk); n++; end
    chk(w == 1 ? "lat_d1" : "lat_d32", n, w == 1 ? 32 : 1);
    chk(w == 1 ? "res_d1" : "res_d32", w == 1 ? result1 : result32, 8);
  endtask

  initial begin
    int nb;
    repeat (2) @(negedge clk);
    chk("reset_state", {busy, done, carry, overflow, zero, illegal, result}, 0);
    rst_n = 1;
    @(negedge clk);

    // 1: basic add, busy window and result hold
    issue(F_ADD, 32'd5, 32'd3);
    nb = 0;
    while (!done && nb < 50) begin if (busy) nb++; @(negedge clk); end
    chk("busy_cycles", nb, 8);
    drain();
    repeat (3) @(negedge clk);
    chk("hold", result, 8);

    // 2, 3: overflow / borrow / zero and SLT corners
    issue(F_ADD, 32'h7FFFFFFF, 32'd1);
    issue(F_SUB, 32'd5, 32'd7);
    issue(F_SUB, 32'd9, 32'd9);
    issue(F_SLT, 32'hFFFFFFFF, 32'd1);
    issue(F_SLT, 32'h7FFFFFFF, 32'h80000000);
    issue(F_SLT, 32'd3, 32'd3);
    issue(F_ADD, 32'hFFFFFFFF, 32'd1);
    issue(F_SUB, 32'h80000000, 32'd1);
    drain();

    // 4: start held every cycle, only idle/done cycles accept
    for (int i = 0; i < 45; i++) begin
      exp_t e;
      logic [5:0] f;
      case ($urandom_range(2)) 0: f = F_ADD; 1: f = F_SUB; default: f = F_SLT; endcase
      funct = f; a = $urandom; b = $urandom; start = 1;
      if (!busy) begin
        e = model(f, a, b);
        e.acc = cyc + 1;
        q.push_back(e);
      end
      @(negedge clk);
    end
    start = 0;
    drain();

    // 5: reset mid-RUN discards the op
    issue(F_ADD, 32'h12345678, 32'h11111111);
    repeat (3) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    q.delete();
    chk("rst_mid", {busy, done, carry, overflow, zero, illegal, result}, 0);
    repeat (12) @(negedge clk);
    issue(F_ADD, 32'd1, 32'd1);
    drain();

    // 6: illegal funct, then degenerate digit widths
    issue(6'b100100, 32'd5, 32'd3);
    drain();
    issue(F_ADD, 32'd5, 32'd3);
    drain();
    alt(1);
    alt(32);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
